// File: rtl/load_store_unit_if.sv
// Request/response handshake and mem2IO/SRAM port bundle for the load/store unit.
// The slave modport is the LSU itself; the master side is the control FSM plus memory.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_oe;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_we, funct3, addr, wdata, mem_rdata,
    input  req_ready, resp_valid, rdata, err,
           mem_addr, mem_wdata, mem_be, mem_oe, mem_we
  );

  modport slave (
    input  req_valid, req_we, funct3, addr, wdata, mem_rdata,
    output req_ready, resp_valid, rdata, err,
           mem_addr, mem_wdata, mem_be, mem_oe, mem_we
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store sequencer between the RISC-V control FSM and the mem2IO/SRAM port:
// lane alignment, byte enables, fixed wait-state strobes, load extension and error flagging.
module load_store_unit #(
  parameter int WAIT_CYCLES = 2
) (
  input logic               Clk,
  input logic               Reset_n,
  load_store_unit_if.slave  bus
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("load_store_unit: WAIT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             store_q, store_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       off_q, off_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic        legal_f3;
  logic        misaligned;
  logic [3:0]  be_req;
  logic [31:0] wdata_req;
  logic [31:0] lane;
  logic [31:0] load_ext;

  // Decode the incoming request; funct3[1:0] encodes the access width for both loads and stores.
  always_comb begin
    legal_f3   = bus.req_we ? (bus.funct3 inside {3'b000, 3'b001, 3'b010})
                            : (bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                 ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    be_req     = 4'b1111;
    wdata_req  = bus.wdata;
    case (bus.funct3[1:0])
      2'b00: begin
        be_req    = 4'b0001 << bus.addr[1:0];
        wdata_req = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        be_req    = 4'b0011 << bus.addr[1:0];
        wdata_req = {2{bus.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane = bus.mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'h0, lane[7:0]};
      3'b101:  load_ext = {16'h0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    store_d     = store_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          store_d    = bus.req_we;
          funct3_d   = bus.funct3;
          off_d      = bus.addr[1:0];
          mem_addr_d = {bus.addr[31:2], 2'b00};
          rdata_d    = 32'h0;
          cnt_d      = '0;
          // Illegal requests skip the memory entirely and respond on the next cycle.
          if (legal_f3 && !misaligned) begin
            err_d       = 1'b0;
            mem_be_d    = be_req;
            mem_wdata_d = wdata_req;
            state_d     = SETUP;
          end else begin
            err_d       = 1'b1;
            mem_be_d    = 4'b0000;
            mem_wdata_d = 32'h0;
            state_d     = RESP;
          end
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          if (!store_q) rdata_d = load_ext;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'b0000;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them immediately.
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.mem_oe     = (state_q == ACCESS) && !store_q;
  assign bus.mem_we     = (state_q == ACCESS) && store_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.rdata      = rdata_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with WAIT_CYCLES = 2.
// Expected values are hand-computed from the load/store alignment and extension rules.
module tb_load_store_unit;

  logic Clk = 1'b0;
  logic Reset_n;

  load_store_unit_if bus ();

  load_store_unit #(.WAIT_CYCLES(2)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  int   passed = 0;
  int   failed = 0;
  int   total  = 0;
  int   lat;
  int   oe_cnt;
  int   we_cnt;
  logic overlap = 1'b0;
  logic resp_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits at negedges from the current point until resp_valid, tallying strobe cycles.
  task automatic wait_resp();
    lat    = 0;
    oe_cnt = 0;
    we_cnt = 0;
    while (bus.resp_valid !== 1'b1 && lat < 40) begin
      if (bus.mem_oe === 1'b1) oe_cnt++;
      if (bus.mem_we === 1'b1) we_cnt++;
      if (bus.mem_oe === 1'b1 && bus.mem_we === 1'b1) overlap = 1'b1;
      @(negedge Clk);
      lat++;
    end
  endtask

  task automatic apply_stimulus(input logic we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd);
    @(negedge Clk);
    bus.req_we    = we;
    bus.funct3    = f3;
    bus.addr      = a;
    bus.wdata     = wd;
    bus.req_valid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    bus.req_valid = 1'b0;
    wait_resp();
  endtask

  task automatic check_output(input string tag, input int exp_lat, input logic [31:0] exp_rdata,
                              input logic exp_err, input int exp_oe, input int exp_we);
    check({tag, "_lat"},   32'(lat),    32'(exp_lat));
    check({tag, "_rdata"}, bus.rdata,   exp_rdata);
    check({tag, "_err"},   32'(bus.err), 32'(exp_err));
    check({tag, "_oecyc"}, 32'(oe_cnt), 32'(exp_oe));
    check({tag, "_wecyc"}, 32'(we_cnt), 32'(exp_we));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.funct3    = 3'b000;
    bus.addr      = 32'h0;
    bus.wdata     = 32'h0;
    bus.mem_rdata = 32'h80FF_7F01;
    repeat (2) @(negedge Clk);
    check("rst_ready",  32'(bus.req_ready),  32'd1);
    check("rst_resp",   32'(bus.resp_valid), 32'd0);
    check("rst_err",    32'(bus.err),        32'd0);
    check("rst_oe",     32'(bus.mem_oe),     32'd0);
    check("rst_we",     32'(bus.mem_we),     32'd0);
    check("rst_rdata",  bus.rdata,           32'h0);
    check("rst_maddr",  bus.mem_addr,        32'h0);
    check("rst_mwdata", bus.mem_wdata,       32'h0);
    check("rst_be",     32'(bus.mem_be),     32'h0);
    Reset_n = 1'b1;

    // Loads against mem_rdata = 80FF_7F01
    apply_stimulus(1'b0, 3'b000, 32'h0000_0102, 32'h0);
    check_output("lb2", 3, 32'hFFFF_FFFF, 1'b0, 2, 0);
    check("lb2_maddr", bus.mem_addr,    32'h0000_0100);
    check("lb2_be",    32'(bus.mem_be), 32'h4);
    apply_stimulus(1'b0, 3'b101, 32'h0000_0102, 32'h0);
    check_output("lhu2", 3, 32'h0000_80FF, 1'b0, 2, 0);
    check("lhu2_be", 32'(bus.mem_be), 32'hC);
    apply_stimulus(1'b0, 3'b001, 32'h0000_0102, 32'h0);
    check_output("lh2", 3, 32'hFFFF_80FF, 1'b0, 2, 0);
    apply_stimulus(1'b0, 3'b100, 32'h0000_0101, 32'h0);
    check_output("lbu1", 3, 32'h0000_007F, 1'b0, 2, 0);
    apply_stimulus(1'b0, 3'b000, 32'h0000_0103, 32'h0);
    check_output("lb3", 3, 32'hFFFF_FF80, 1'b0, 2, 0);
    apply_stimulus(1'b0, 3'b010, 32'h0000_0104, 32'h0);
    check_output("lw", 3, 32'h80FF_7F01, 1'b0, 2, 0);
    check("lw_maddr", bus.mem_addr,    32'h0000_0104);
    check("lw_be",    32'(bus.mem_be), 32'hF);

    // Stores
    apply_stimulus(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD);
    check_output("sh2", 3, 32'h0, 1'b0, 0, 2);
    check("sh2_be",     32'(bus.mem_be), 32'hC);
    check("sh2_mwdata", bus.mem_wdata,   32'hABCD_ABCD);
    apply_stimulus(1'b1, 3'b000, 32'h0000_0203, 32'h0000_005A);
    check_output("sb3", 3, 32'h0, 1'b0, 0, 2);
    check("sb3_be",     32'(bus.mem_be), 32'h8);
    check("sb3_mwdata", bus.mem_wdata,   32'h5A5A_5A5A);

    // Error cases: previous load left rdata nonzero, so a cleared rdata is observable
    apply_stimulus(1'b0, 3'b010, 32'h0000_0104, 32'h0);
    apply_stimulus(1'b0, 3'b010, 32'h0000_0101, 32'h0);
    check_output("lw_mis", 0, 32'h0, 1'b1, 0, 0);
    check("lw_mis_be", 32'(bus.mem_be), 32'h0);
    apply_stimulus(1'b1, 3'b100, 32'h0000_0200, 32'hFFFF_FFFF);
    check_output("st_badf3", 0, 32'h0, 1'b1, 0, 0);
    apply_stimulus(1'b0, 3'b001, 32'h0000_0103, 32'h0);
    check_output("lh_mis", 0, 32'h0, 1'b1, 0, 0);
    apply_stimulus(1'b0, 3'b110, 32'h0000_0100, 32'h0);
    check_output("ld_badf3", 0, 32'h0, 1'b1, 0, 0);

    // Back-to-back: req_valid held high for SW then LW
    @(negedge Clk);
    bus.req_we    = 1'b1;
    bus.funct3    = 3'b010;
    bus.addr      = 32'h0000_0300;
    bus.wdata     = 32'hDEAD_BEEF;
    bus.req_valid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    bus.req_we    = 1'b0;
    bus.addr      = 32'h0000_0304;
    bus.mem_rdata = 32'h1357_9BDF;
    wait_resp();
    check("b2b_sw_lat",    32'(lat),           32'd3);
    check("b2b_sw_wecyc",  32'(we_cnt),        32'd2);
    check("b2b_sw_mwdata", bus.mem_wdata,      32'hDEAD_BEEF);
    check("b2b_resp_rdy",  32'(bus.req_ready), 32'd0);
    @(negedge Clk);
    check("b2b_idle_rdy",  32'(bus.req_ready), 32'd1);
    @(posedge Clk);
    @(negedge Clk);
    bus.req_valid = 1'b0;
    check("b2b_lw_maddr",  bus.mem_addr,       32'h0000_0304);
    check("b2b_lw_rdy",    32'(bus.req_ready), 32'd0);
    wait_resp();
    check_output("b2b_lw", 3, 32'h1357_9BDF, 1'b0, 2, 0);
    check("no_overlap", 32'(overlap), 32'd0);

    // Async reset in the middle of a store's strobe window
    @(negedge Clk);
    bus.req_we    = 1'b1;
    bus.funct3    = 3'b010;
    bus.addr      = 32'h0000_0400;
    bus.wdata     = 32'h0BAD_F00D;
    bus.req_valid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    bus.req_valid = 1'b0;
    lat = 0;
    while (bus.mem_we !== 1'b1 && lat < 10) begin
      @(negedge Clk);
      lat++;
    end
    check("arst_we_before", 32'(bus.mem_we), 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    check("arst_we",    32'(bus.mem_we),     32'd0);
    check("arst_ready", 32'(bus.req_ready),  32'd1);
    check("arst_resp",  32'(bus.resp_valid), 32'd0);
    check("arst_be",    32'(bus.mem_be),     32'h0);
    @(negedge Clk);
    Reset_n   = 1'b1;
    resp_seen = 1'b0;
    repeat (8) begin
      @(negedge Clk);
      if (bus.resp_valid === 1'b1) resp_seen = 1'b1;
    end
    check("arst_no_resp", 32'(resp_seen), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
